// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Purpose  : Elastic pipeline-stage register with a 2-entry skid buffer,
//            flush-to-bubble and a saturating backpressure counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int                DATA_W      = 64,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = {32'h0, 32'h00000013},
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  bp_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] w_main_nxt;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_skid_nxt;
    logic              r_in_ready;
    logic [CNT_W-1:0]  r_bp_cnt;
    logic              w_push;
    logic              w_pop;

    assign out_valid = (r_state != S_EMPTY);
    assign out_data  = r_main;
    assign in_ready  = r_in_ready;
    assign bp_cnt    = r_bp_cnt;
    assign w_push    = in_valid & r_in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_main     <= BUBBLE_DATA;
            r_skid     <= BUBBLE_DATA;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
            // Registered from next state so in_ready has no path from out_ready
            r_in_ready <= (w_state_nxt != S_TWO);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = S_EMPTY;
            w_main_nxt  = BUBBLE_DATA;
            w_skid_nxt  = BUBBLE_DATA;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt = S_ONE;
                        w_main_nxt  = in_data;
                    end
                end
                S_ONE: begin
                    case ({w_push, w_pop})
                        2'b11: w_main_nxt = in_data;
                        2'b10: begin
                            w_state_nxt = S_TWO;
                            w_skid_nxt  = in_data;
                        end
                        2'b01: begin
                            w_state_nxt = S_EMPTY;
                            w_main_nxt  = BUBBLE_DATA;
                        end
                        default: ;
                    endcase
                end
                S_TWO: begin
                    if (w_pop) begin
                        w_state_nxt = S_ONE;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = BUBBLE_DATA;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                    w_main_nxt  = BUBBLE_DATA;
                    w_skid_nxt  = BUBBLE_DATA;
                end
            endcase
        end
    end

    always_comb begin
        occupancy = 2'd0;
        case (r_state)
            S_ONE:   occupancy = 2'd1;
            S_TWO:   occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bp_cnt <= '0;
        end else if (cnt_clr) begin
            r_bp_cnt <= '0;
        end else if (out_valid && !out_ready && (r_bp_cnt != c_CNT_MAX)) begin
            r_bp_cnt <= r_bp_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire
